expr_tx: RTL
============

Name: expr_tx

Overview:
- Serializing transmitter for the ASCII expression-string protocol. It emits alternating digit/operator characters such as "1*2*3", one byte per accepted beat.
- It is the source end of the stream that the string-recognizer block consumes on its 8-bit `in` port.
- Used to drive the recognizer in system tests, and as a stimulus generator in place of hand-written byte sequences.

Parameters:
- MAX_TERMS, 8, maximum operands per expression (2..15).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- clr, input, 1, synchronous active-high reset.
- start, input, 1, request to transmit; sampled only in IDLE.
- num_terms, input, 4, operand count for this request (valid 1..MAX_TERMS).
- digits, input, 4*MAX_TERMS, operand values, term k at [4k+3:4k], term 0 sent first.
- ops, input, MAX_TERMS-1, operator k between term k and k+1: 0 = '+', 1 = '*'.
- ready, input, 1, consumer accepts the current byte this cycle.
- out, output, 8, ASCII character.
- out_valid, output, 1, out holds a valid character.
- busy, output, 1, request in progress.
- done, output, 1, one-cycle pulse after the final byte is accepted.
- err, output, 1, one-cycle pulse on a rejected request.

Behaviour:
- Clock and reset: one clock (clk); reset clr is synchronous and active-high.
- Reset values (clr high at an edge): state = IDLE; out = 8'h00; out_valid = 0; busy = 0; done = 0; err = 0.
  - clr mid-transfer aborts immediately.
  - No done pulse is produced for an aborted transfer.
- States: IDLE, DIGIT, OP.
- IDLE:
  - On start = 1, validate the request: num_terms in 1..MAX_TERMS, and every used digit field ≤ 9.
  - Valid request: latch digits, ops and num_terms; term index = 0; go to DIGIT. In the next cycle out_valid = 1 and out = "0" + digit[0] (latency 1).
  - Invalid request: err = 1 for one cycle; stay IDLE; registers unchanged.
- Handshake:
  - A byte transfers on a cycle with out_valid && ready.
  - While ready = 0, out and out_valid hold stable.
  - out_valid never drops before the transfer.
- DIGIT, on transfer:
  - If index == num_terms-1: go to IDLE, out_valid = 0, out = 8'h00, done = 1 for one cycle.
  - Otherwise: go to OP with out = ops[index] ? "*" : "+".
- OP, on transfer: index++; go to DIGIT with out = "0" + digit[index].
- Frame length: exactly 2*num_terms-1 bytes; num_terms = 1 sends a single digit.
- busy = 1 in DIGIT/OP; 0 in IDLE, including the done cycle.
- Back-to-back: start is honoured in the same cycle done is high, because the state is already IDLE.
- start while busy is ignored, with no err.
- Input stability: digits/ops/num_terms may change freely after acceptance (latched copy is used).
- Unused fields: digit and op fields beyond num_terms are don't-care and are not validated.
- Output width: out is always a full 8-bit ASCII code; digits are "0"(8'h30)..."9"(8'h39).

Optional Feature:
- Macro EXPR_TX_TERM_EN.
- When defined, a state TERM follows the last digit and emits ";" (8'h3B). done pulses after the ";" transfer. Frame length = 2*num_terms.
- When undefined, the TERM state and its logic are absent, and the behaviour is as above.

Decomposition:
- Shared package/header expr_pkg:
  - ASCII constants CH_0, CH_PLUS, CH_STAR, CH_TERM.
  - State encodings ST_IDLE, ST_DIGIT, ST_OP, ST_TERM.
  - Op encoding OP_ADD = 0, OP_MUL = 1.
- Sub-module expr_tx_req_check (combinational validation of num_terms/digits, outputs ok) is natural. Everything else stays in expr_tx.

Test Plan:
- "1*2*3" with ready tied 1: num_terms = 3, digits = {3,2,1}, ops = 2'b11, start one cycle.
  - out = "1","*","2","*","3" on 5 consecutive cycles starting 1 cycle after start.
  - done pulses on the 6th cycle.
  - Recognizer instance downstream reports match.
- Backpressure: same request with ready low for 3 cycles while out = "*".
  - out/out_valid stable during the stall.
  - Sequence unchanged; done delayed by 3 cycles.
- Rejection:
  - num_terms = 0 → err pulse, busy stays 0, out_valid stays 0.
  - num_terms = 2 with digit[1] = 12 → err pulse.
  - num_terms = 2 with digit[2] = 15 (unused) → accepted, sends "x+y".
- Single term and back-to-back:
  - num_terms = 1, digit = 7 → one byte "7", then done.
  - start held high in the done cycle with "4+5" → "4","+","5" follow with no idle gap beyond 1 cycle.
- clr mid-frame: assert clr while out = "2".
  - Next cycle out = 8'h00, out_valid = 0, busy = 0, no done.
  - A new start then works normally.
- EXPR_TX_TERM_EN build: "1*2" → "1","*","2",";"; done after ";".

Source files
------------

// File: rtl/expr_pkg.sv
// Shared constants for the expression-string transmitter: ASCII codes, FSM states, op encoding.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_TERM = 8'h3B;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_OP    = 2'd2,
    ST_TERM  = 2'd3
  } state_t;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return CH_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/expr_tx_req_check.sv
// Combinational request validation: operand count in range and every used digit is decimal.
module expr_tx_req_check
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8
) (
  input  logic [3:0]             num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  output logic                   ok
);

  logic [MAX_TERMS-1:0] bad;

  // Fields at or beyond num_terms are don't-care and never flagged.
  for (genvar gi = 0; gi < MAX_TERMS; gi++) begin : g_digit
    assign bad[gi] = (num_terms > 4'(gi)) && (digits[4*gi +: 4] > 4'd9);
  end

  assign ok = (num_terms != 4'd0) && (num_terms <= 4'(MAX_TERMS)) && (bad == '0);

endmodule

// File: rtl/expr_tx.sv
// Serializing transmitter for "d op d op d" ASCII expressions, one byte per ready beat.
// Optional build macro EXPR_TX_TERM_EN appends ';' after the last digit.
module expr_tx
  import expr_pkg::*;
#(
  parameter int MAX_TERMS = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [3:0]             num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic                   ready,
  output logic [7:0]             out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t                 state_reg;
  logic [3:0]             idx_reg;
  logic [3:0]             num_reg;
  logic [4*MAX_TERMS-1:0] digits_reg;
  logic [MAX_TERMS-2:0]   ops_reg;
  logic [7:0]             out_reg;
  logic                   out_valid_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   err_reg;

  logic       req_ok;
  logic       xfer;
  logic       last_term;
  logic       cur_op;
  logic [3:0] next_digit;

  expr_tx_req_check #(.MAX_TERMS(MAX_TERMS)) u_req_check (
    .num_terms (num_terms),
    .digits    (digits),
    .ok        (req_ok)
  );

  always_comb begin
    xfer       = out_valid_reg && ready;
    last_term  = (idx_reg == num_reg - 4'd1);
    cur_op     = OP_ADD;
    next_digit = 4'd0;
    for (int i = 0; i < MAX_TERMS - 1; i++) begin
      if (idx_reg == 4'(i)) cur_op = ops_reg[i];
    end
    // Digit that follows the operator currently on the wire.
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (idx_reg + 4'd1 == 4'(i)) next_digit = digits_reg[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= 4'd0;
      num_reg       <= 4'd0;
      digits_reg    <= '0;
      ops_reg       <= '0;
      out_reg       <= 8'h00;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (req_ok) begin
              digits_reg    <= digits;
              ops_reg       <= ops;
              num_reg       <= num_terms;
              idx_reg       <= 4'd0;
              state_reg     <= ST_DIGIT;
              out_reg       <= ascii_digit(digits[3:0]);
              out_valid_reg <= 1'b1;
              busy_reg      <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_DIGIT: begin
          if (xfer) begin
            if (last_term) begin
`ifdef EXPR_TX_TERM_EN
              state_reg <= ST_TERM;
              out_reg   <= CH_TERM;
`else
              state_reg     <= ST_IDLE;
              out_reg       <= 8'h00;
              out_valid_reg <= 1'b0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
`endif
            end else begin
              state_reg <= ST_OP;
              out_reg   <= (cur_op == OP_MUL) ? CH_STAR : CH_PLUS;
            end
          end
        end
        ST_OP: begin
          if (xfer) begin
            idx_reg   <= idx_reg + 4'd1;
            state_reg <= ST_DIGIT;
            out_reg   <= ascii_digit(next_digit);
          end
        end
`ifdef EXPR_TX_TERM_EN
        ST_TERM: begin
          if (xfer) begin
            state_reg     <= ST_IDLE;
            out_reg       <= 8'h00;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end
        end
`endif
        default: begin
          state_reg     <= ST_IDLE;
          out_reg       <= 8'h00;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule
